// File: rtl/melody_frame_if.sv
// melody_frame_if: request/symbol bus between a frame requester and melody_frame_tx
//   master drives start/req_type/payload; slave (the transmitter) drives ready/ok/tone/note/done/err
interface melody_frame_if;
  logic       start;
  logic [1:0] req_type;
  logic       p1_tone;
  logic [2:0] p1_note;
  logic       p2_tone;
  logic [2:0] p2_note;
  logic       ready;
  logic       ok;
  logic       tone;
  logic [2:0] note;
  logic       done;
  logic       err;
  modport master (
    output start, req_type, p1_tone, p1_note, p2_tone, p2_note,
    input  ready, ok, tone, note, done, err
  );
  modport slave (
    input  start, req_type, p1_tone, p1_note, p2_tone, p2_note,
    output ready, ok, tone, note, done, err
  );
endinterface

// File: rtl/melody_frame_tx.sv
// melody_frame_tx: sends one 6-symbol melody frame (F, tense, p1, p2, G, X), one symbol per ok pulse
//   clk   rising-edge clock
//   reset synchronous active-low reset
//   bus   slave side: start/req_type/p1_*/p2_* in; ready/ok/tone/note/done/err out (all registered)
module melody_frame_tx #(
  parameter int GAP = 1
) (
  input logic           clk,
  input logic           reset,
  melody_frame_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SEND, GAP_WAIT, DONE, ERR} state_t;
  localparam logic [3:0] GAP_M1 = 4'(GAP == 0 ? 0 : GAP - 1);
  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d, idx_nxt;
  logic [3:0] gap_q, gap_d;
  logic [1:0] type_q, type_d;
  logic       p1t_q, p1t_d, p2t_q, p2t_d;
  logic [2:0] p1n_q, p1n_d, p2n_q, p2n_d;
  logic       ready_q, ready_d, ok_q, ok_d, tone_q, tone_d, done_q, done_d, err_q, err_d;
  logic [2:0] note_q, note_d;
  logic [3:0] sym_nxt;
  logic       bad_req;
  assign idx_nxt = idx_q == 3'd5 ? 3'd5 : idx_q + 3'd1;
  assign bad_req = bus.req_type == 2'b00 || bus.p1_note == 3'b000 || bus.p2_note == 3'b000;
  // {tone,note} of the symbol following the current index; symbol 0 is only ever sent at acceptance
  always_comb
    sym_nxt = idx_nxt == 3'd1 ? {1'b1, type_q == 2'b01 ? 3'b001 : type_q == 2'b10 ? 3'b100 : 3'b111} :
              idx_nxt == 3'd2 ? {p1t_q, p1n_q} :
              idx_nxt == 3'd3 ? {p2t_q, p2n_q} :
              idx_nxt == 3'd4 ? 4'b0101 : 4'b0000;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    type_d  = type_q;
    p1t_d   = p1t_q;
    p1n_d   = p1n_q;
    p2t_d   = p2t_q;
    p2n_d   = p2n_q;
    ready_d = 1'b0;
    ok_d    = 1'b0;
    tone_d  = tone_q;
    note_d  = note_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (bus.start) begin
          type_d  = bus.req_type;
          p1t_d   = bus.p1_tone;
          p1n_d   = bus.p1_note;
          p2t_d   = bus.p2_tone;
          p2n_d   = bus.p2_note;
          ready_d = 1'b0;
          state_d = bad_req ? ERR : SEND;
          err_d   = bad_req;
          ok_d    = !bad_req;
          idx_d   = 3'd0;
          if (!bad_req) {tone_d, note_d} = 4'b0100;
        end
      end
      SEND: begin
        if (idx_q == 3'd5) begin
          state_d          = DONE;
          done_d           = 1'b1;
          {tone_d, note_d} = 4'b0000;
        end else if (GAP == 0) begin
          idx_d            = idx_nxt;
          ok_d             = 1'b1;
          {tone_d, note_d} = sym_nxt;
        end else begin
          state_d = GAP_WAIT;
          gap_d   = GAP_M1;
        end
      end
      GAP_WAIT: begin
        if (gap_q == 4'd0) begin
          state_d          = SEND;
          idx_d            = idx_nxt;
          ok_d             = 1'b1;
          {tone_d, note_d} = sym_nxt;
        end else gap_d = gap_q - 4'd1;
      end
      DONE, ERR: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      gap_q   <= 4'd0;
      type_q  <= 2'b00;
      p1t_q   <= 1'b0;
      p1n_q   <= 3'b000;
      p2t_q   <= 1'b0;
      p2n_q   <= 3'b000;
      ready_q <= 1'b1;
      ok_q    <= 1'b0;
      tone_q  <= 1'b0;
      note_q  <= 3'b000;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      type_q  <= type_d;
      p1t_q   <= p1t_d;
      p1n_q   <= p1n_d;
      p2t_q   <= p2t_d;
      p2n_q   <= p2n_d;
      ready_q <= ready_d;
      ok_q    <= ok_d;
      tone_q  <= tone_d;
      note_q  <= note_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  assign bus.ready = ready_q;
  assign bus.ok    = ok_q;
  assign bus.tone  = tone_q;
  assign bus.note  = note_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;
endmodule

// File: tb/tb_melody_frame_tx.sv
// tb_melody_frame_tx: three transmitters (GAP=1,0,2) on shared inputs checked every cycle against a frame-timing model
module tb_melody_frame_tx;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [1:0] req_type = 2'b00;
  logic       p1_tone = 1'b0, p2_tone = 1'b0;
  logic [2:0] p1_note = 3'b000, p2_note = 3'b000;
  logic       rdy [3], okk [3], tn [3], dn [3], er [3];
  logic [2:0] nt [3];
  int         cyc = 0, passed = 0, total = 0;
  logic       m_act [3], m_bad [3], m_t1 [3], m_t2 [3];
  int         m_acc [3];
  logic [1:0] m_ty [3];
  logic [2:0] m_n1 [3], m_n2 [3];
  logic [3:0] lit_sym [6];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : gd
    localparam int G = g == 0 ? 1 : g == 1 ? 0 : 2;
    melody_frame_if bus ();
    assign bus.start    = start;
    assign bus.req_type = req_type;
    assign bus.p1_tone  = p1_tone;
    assign bus.p1_note  = p1_note;
    assign bus.p2_tone  = p2_tone;
    assign bus.p2_note  = p2_note;
    melody_frame_tx #(.GAP(G)) dut (.clk(clk), .reset(reset), .bus(bus));
    assign rdy[g] = bus.ready;
    assign okk[g] = bus.ok;
    assign tn[g]  = bus.tone;
    assign nt[g]  = bus.note;
    assign dn[g]  = bus.done;
    assign er[g]  = bus.err;
  end
  function automatic int gap_of(int i);
    return i == 0 ? 1 : i == 1 ? 0 : 2;
  endfunction
  function automatic logic [3:0] sym(int i, int s);
    case (s)
      0: return 4'b0100;
      1: return {1'b1, m_ty[i] == 2'b01 ? 3'b001 : m_ty[i] == 2'b10 ? 3'b100 : 3'b111};
      2: return {m_t1[i], m_n1[i]};
      3: return {m_t2[i], m_n2[i]};
      4: return 4'b0101;
      default: return 4'b0000;
    endcase
  endfunction
  // expected {ready, ok, tone, note[2:0], done, err} in the current cycle; k counts cycles since acceptance
  function automatic logic [7:0] expect_out(int i);
    int k, g, len;
    g   = gap_of(i);
    len = 6 + 5 * g;
    k   = cyc - m_acc[i] + 1;
    if (!m_act[i]) return 8'b1000_0000;
    if (m_bad[i]) return k == 1 ? 8'b0000_0001 : 8'b1000_0000;
    if (k <= len) return {1'b0, ((k - 1) % (g + 1)) == 0, sym(i, (k - 1) / (g + 1)), 2'b00};
    if (k == len + 1) return 8'b0000_0010;
    return 8'b1000_0000;
  endfunction
  task automatic model_update();
    logic [7:0] e;
    for (int i = 0; i < 3; i++) begin
      e = expect_out(i);
      if (!reset) m_act[i] = 1'b0;
      else if (e[7] && start) begin
        m_act[i] = 1'b1;
        m_bad[i] = req_type == 2'b00 || p1_note == 3'b000 || p2_note == 3'b000;
        m_acc[i] = cyc + 1;
        m_ty[i]  = req_type;
        m_t1[i]  = p1_tone;
        m_n1[i]  = p1_note;
        m_t2[i]  = p2_tone;
        m_n2[i]  = p2_note;
      end
    end
    cyc++;
  endtask
  task automatic chk(input int i, input string nm, input int got, input int want);
    total++;
    if (got == want) passed++;
    else $display("FAIL d%0d_%s cyc=%0d got=%0d want=%0d", i, nm, cyc, got, want);
  endtask
  task automatic lit(input string nm, input int got, input int want);
    total++;
    if (got == want) passed++;
    else $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, got, want);
  endtask
  task automatic compare_all();
    logic [7:0] e;
    for (int i = 0; i < 3; i++) begin
      e = expect_out(i);
      chk(i, "ready", rdy[i], e[7]);
      chk(i, "ok", okk[i], e[6]);
      chk(i, "tone", tn[i], e[5]);
      chk(i, "note", nt[i], e[4:2]);
      chk(i, "done", dn[i], e[1]);
      chk(i, "err", er[i], e[0]);
    end
  endtask
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask
  task automatic req(input logic [1:0] ty, input logic t1, input logic [2:0] n1, input logic t2, input logic [2:0] n2);
    req_type = ty;
    p1_tone  = t1;
    p1_note  = n1;
    p2_tone  = t2;
    p2_note  = n2;
    start    = 1'b1;
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      m_act[i] = 1'b0;
      m_bad[i] = 1'b0;
      m_acc[i] = 0;
    end
    lit_sym[0] = 4'b0100;
    lit_sym[1] = 4'b1001;
    lit_sym[2] = 4'b1010;
    lit_sym[3] = 4'b0011;
    lit_sym[4] = 4'b0101;
    lit_sym[5] = 4'b0000;
    req(2'b01, 1'b1, 3'b010, 1'b0, 3'b011);
    repeat (3) begin
      step();
      lit("rst_ready", rdy[0], 1);
      lit("rst_ok", okk[0], 0);
      lit("rst_note", nt[0], 0);
      lit("rst_done", dn[0], 0);
      lit("rst_err", er[0], 0);
    end
    reset = 1'b1;
    start = 1'b0;
    step();
    lit("post_rst_ready", rdy[0], 1);
    req(2'b01, 1'b1, 3'b010, 1'b0, 3'b011);
    for (int k = 1; k <= 13; k++) begin
      step();
      if (k <= 11) begin
        lit("f1_ok", okk[0], k % 2);
        if (k % 2 == 1) lit("f1_sym", {tn[0], nt[0]}, lit_sym[(k - 1) / 2]);
      end
      if (k == 12) lit("f1_done", dn[0], 1);
      if (k == 13) lit("f1_ready", rdy[0], 1);
      start = k == 4;
      if (k == 2) p1_note = 3'b110;
    end
    repeat (20) step();
    req(2'b11, 1'b0, 3'b110, 1'b1, 3'b101);
    for (int k = 1; k <= 8; k++) begin
      step();
      start = 1'b0;
      if (k <= 6) lit("f2_ok", okk[1], 1);
      if (k == 2) lit("f2_sym1", {tn[1], nt[1]}, 4'b1111);
      if (k == 7) lit("f2_done", dn[1], 1);
      if (k == 8) lit("f2_ready", rdy[1], 1);
    end
    repeat (20) step();
    for (int t = 0; t < 2; t++) begin
      if (t == 0) req(2'b00, 1'b0, 3'b001, 1'b0, 3'b010);
      else req(2'b10, 1'b1, 3'b011, 1'b0, 3'b000);
      step();
      start = 1'b0;
      lit("ill_err", er[0], 1);
      lit("ill_ok", okk[0], 0);
      lit("ill_ready0", rdy[0], 0);
      step();
      lit("ill_ready1", rdy[0], 1);
      repeat (20) step();
    end
    req(2'b10, 1'b0, 3'b001, 1'b1, 3'b010);
    for (int k = 1; k <= 4; k++) begin
      step();
      start = 1'b0;
    end
    reset = 1'b0;
    step();
    lit("mrst_ready", rdy[0], 1);
    lit("mrst_ok", okk[0], 0);
    reset = 1'b1;
    repeat (3) begin
      step();
      lit("mrst_no_ok", okk[0], 0);
    end
    req(2'b10, 1'b0, 3'b001, 1'b1, 3'b010);
    step();
    start = 1'b0;
    repeat (20) step();
    for (int n = 0; n < 3000; n++) begin
      start    = $urandom_range(0, 3) == 0;
      req_type = 2'($urandom_range(0, 3));
      p1_tone  = 1'($urandom_range(0, 1));
      p1_note  = 3'($urandom_range(0, 7));
      p2_tone  = 1'($urandom_range(0, 1));
      p2_note  = 3'($urandom_range(0, 7));
      reset    = $urandom_range(0, 99) != 0;
      step();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
